// File: rtl/vbuffer_fetch.sv
// Vertex-buffer fetch engine: walks a contiguous RAM range and streams each word out through a 2-entry queue.
// Optional degenerate-triangle culling is compiled in when VBUFFER_FETCH_DEGEN_CULL_EN is defined.
module vbuffer_fetch #(
    parameter int DATA_WIDTH = 216,
    parameter int ADDR_WIDTH = 12
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   count,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   out_index,
    output logic                  out_last
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [ADDR_WIDTH:0] ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   base_q, base_d;
    logic [ADDR_WIDTH-1:0]   hold_q, hold_d;
    logic [ADDR_WIDTH:0]     count_q, count_d;
    logic [ADDR_WIDTH:0]     issued_q, issued_d;
    logic [ADDR_WIDTH:0]     emit_q, emit_d;
    logic                    inflight_q, inflight_d;
    logic [1:0]              occ_q, occ_d;
    logic [DATA_WIDTH-1:0]   ent0_q, ent0_d;
    logic [DATA_WIDTH-1:0]   ent1_q, ent1_d;

    logic                    keep;
    logic                    push;
    logic                    pop;
    logic                    issue;
    logic [ADDR_WIDTH-1:0]   issue_addr;

`ifdef VBUFFER_FETCH_DEGEN_CULL_EN
    localparam int VW = DATA_WIDTH / 4;
    logic [VW-1:0] vec0, vec1, vec2;
    logic          all_captured;

    assign vec0 = q[VW-1:0];
    assign vec1 = q[2*VW-1:VW];
    assign vec2 = q[3*VW-1:2*VW];
    assign keep = !((vec0 == vec1) || (vec1 == vec2) || (vec0 == vec2));

    // A lone head word is held back until no later capture can still become the final one,
    // so out_last is known (and stable) the moment the word is offered.
    assign all_captured = (state_q == DRAIN) && !inflight_q;
    assign out_valid    = (occ_q == 2'd2) || ((occ_q == 2'd1) && all_captured);
    assign out_last     = out_valid && (occ_q == 2'd1);
`else
    logic [ADDR_WIDTH:0] last_ord;

    assign keep      = 1'b1;
    assign last_ord  = count_q - ONE;
    assign out_valid = (occ_q != 2'd0);
    assign out_last  = out_valid && (emit_q == last_ord);
`endif

    assign out_data  = ent0_q;
    assign out_index = emit_q;
    assign done      = (state_q == FINISH);
    assign busy      = (state_q != IDLE) || (start && !reset);
    assign read_addr = issue ? issue_addr : hold_q;

    // A slot freed by this cycle's pop may be reused, which is what sustains one word per cycle.
    always_comb begin
        issue_addr = base_q + issued_q[ADDR_WIDTH-1:0];
        pop        = out_valid && out_ready;
        push       = inflight_q && keep;
        issue      = (state_q == FETCH) && (issued_q != count_q) &&
                     ((({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd2) || pop);
    end

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        count_d    = count_q;
        issued_d   = issued_q;
        emit_d     = emit_q;
        hold_d     = hold_q;
        inflight_d = issue;
        occ_d      = occ_q + {1'b0, push} - {1'b0, pop};
        ent0_d     = ent0_q;
        ent1_d     = ent1_q;

        if (issue) begin
            issued_d = issued_q + ONE;
            hold_d   = issue_addr;
        end

        if (pop) begin
            emit_d = emit_q + ONE;
            ent0_d = ent1_q;
        end

        if (push) begin
            if ((occ_q == 2'd0) || ((occ_q == 2'd1) && pop)) begin
                ent0_d = q;
            end else begin
                ent1_d = q;
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    base_d   = base_addr;
                    count_d  = count;
                    issued_d = '0;
                    emit_d   = '0;
                    state_d  = (count == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (issue && (issued_d == count_q)) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if ((occ_d == 2'd0) && !inflight_d) begin
                    state_d = FINISH;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            base_q     <= '0;
            count_q    <= '0;
            issued_q   <= '0;
            emit_q     <= '0;
            hold_q     <= '0;
            inflight_q <= 1'b0;
            occ_q      <= 2'd0;
            ent0_q     <= '0;
            ent1_q     <= '0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            emit_q     <= emit_d;
            hold_q     <= hold_d;
            inflight_q <= inflight_d;
            occ_q      <= occ_d;
            ent0_q     <= ent0_d;
            ent1_q     <= ent1_d;
        end
    end

endmodule

// File: tb/tb_vbuffer_fetch.sv
// Bench for vbuffer_fetch: a RAM model feeds the DUT; each pass is checked against the list of words
// the pass should deliver, derived straight from the memory contents.
module tb_vbuffer_fetch;

    localparam int DW = 216;
    localparam int AW = 12;
    localparam int DEPTH = 4096;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic [AW-1:0] base_addr;
    logic [AW:0]   count;
    logic          busy;
    logic          done;
    logic [AW-1:0] read_addr;
    logic [DW-1:0] q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic [AW:0]   out_index;
    logic          out_last;

    logic [DW-1:0] mem [0:DEPTH-1];
    logic [DW-1:0] expData [$];
    logic [223:0]  tmp;
    int            checks = 0;
    int            failures = 0;

    vbuffer_fetch #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .count     (count),
        .busy      (busy),
        .done      (done),
        .read_addr (read_addr),
        .q         (q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clock = ~clock;

    // Registered-read RAM: data for an address appears the cycle after it is presented.
    always @(posedge clock) q <= mem[read_addr];

    task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

`ifdef VBUFFER_FETCH_DEGEN_CULL_EN
    function automatic bit degenerate(input logic [DW-1:0] w);
        logic [53:0] v0, v1, v2;
        v0 = w[53:0];
        v1 = w[107:54];
        v2 = w[161:108];
        return (v0 == v1) || (v1 == v2) || (v0 == v2);
    endfunction
`endif

    // Words the pass should deliver, in order: entries base..base+cnt-1 modulo the RAM size.
    task automatic buildModel(input int b, input int c);
        logic [DW-1:0] w;
        expData.delete();
        for (int i = 0; i < c; i++) begin
            w = mem[(b + i) % DEPTH];
`ifdef VBUFFER_FETCH_DEGEN_CULL_EN
            if (!degenerate(w)) expData.push_back(w);
`else
            expData.push_back(w);
`endif
        end
    endtask

    // mode 0: out_ready held high; mode 1: ready pattern 1,0,0,1; mode 2: random ready.
    task automatic applyStimulus(input int b, input int c, input int mode, input string name);
        int            k;
        int            lastHs;
        int            budget;
        int            nexp;
        bit            seenDone;
        bit            prevStall;
        logic [DW-1:0] pData;
        logic [AW:0]   pIdx;
        logic          pLast;

        buildModel(b, c);
        nexp = expData.size();
        @(negedge clock);
        start     = 1'b1;
        base_addr = b[AW-1:0];
        count     = c[AW:0];
        out_ready = 1'b1;
        #1;
        checkOutput({name, " busy at start"}, busy, 1);
        @(posedge clock);
        k = 0;
        lastHs = -1;
        seenDone = 0;
        prevStall = 0;
        pData = '0;
        pIdx = '0;
        pLast = 1'b0;
        budget = 8 * c + 40;
        for (int cyc = 0; cyc < budget && !seenDone; cyc++) begin
            @(negedge clock);
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
                default: out_ready = 1'($urandom % 2);
            endcase
            start     = 1'($urandom % 2);
            base_addr = AW'($urandom);
            count     = (AW + 1)'($urandom);
            #1;
            checkOutput({name, " busy during pass"}, busy, 1);
`ifndef VBUFFER_FETCH_DEGEN_CULL_EN
            if (mode == 0 && cyc < c && cyc < 4)
                checkOutput({name, " read_addr"}, read_addr, (b + cyc) % DEPTH);
`endif
            if (prevStall) begin
                checkOutput({name, " valid held in stall"}, out_valid, 1);
                checkOutput({name, " data stable in stall"}, out_data, pData);
                checkOutput({name, " index stable in stall"}, out_index, pIdx);
                checkOutput({name, " last stable in stall"}, out_last, pLast);
            end
            if (out_valid && out_ready) begin
                if (k < nexp) begin
                    checkOutput({name, " out_data"}, out_data, expData[k]);
                    checkOutput({name, " out_index"}, out_index, k);
                    checkOutput({name, " out_last"}, out_last, (k == nexp - 1));
`ifndef VBUFFER_FETCH_DEGEN_CULL_EN
                    if (mode == 0) checkOutput({name, " handshake cycle"}, cyc, k + 2);
`endif
                end else begin
                    checkOutput({name, " extra word count"}, k + 1, nexp);
                end
                k++;
                lastHs = cyc;
            end
            prevStall = out_valid && !out_ready;
            pData = out_data;
            pIdx  = out_index;
            pLast = out_last;
            if (done) begin
                seenDone = 1;
                checkOutput({name, " words at done"}, k, nexp);
                checkOutput({name, " valid at done"}, out_valid, 0);
                if (c == 0) checkOutput({name, " done cycle"}, cyc, 0);
                else if (nexp > 0) checkOutput({name, " done cycle"}, cyc, lastHs + 1);
            end
        end
        if (!seenDone) checkOutput({name, " done timeout"}, 0, 1);
        @(negedge clock);
        start = 1'b0;
        #1;
        checkOutput({name, " busy after done"}, busy, 0);
        checkOutput({name, " done one cycle"}, done, 0);
    endtask

    initial begin
        int b;
        int c;
        reset = 1'b1;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        out_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            tmp = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            mem[i] = tmp[DW-1:0];
        end
        repeat (3) @(posedge clock);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset read_addr", read_addr, 0);
        checkOutput("reset out_valid", out_valid, 0);
        checkOutput("reset out_data", out_data, 0);
        checkOutput("reset out_index", out_index, 0);
        checkOutput("reset out_last", out_last, 0);
        @(negedge clock);
        reset = 1'b0;

        $display("[TB] directed passes");
        applyStimulus(16'h010, 3, 0, "basic3");
        applyStimulus(0, 0, 0, "count0");
        applyStimulus(12'hFFE, 4, 0, "wrap");
        applyStimulus(5, 8, 1, "stall8");

        $display("[TB] reset mid-pass");
        @(negedge clock);
        start = 1'b1;
        base_addr = 12'h200;
        count = 13'd8;
        out_ready = 1'b0;
        @(posedge clock);
        @(negedge clock);
        start = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        checkOutput("midreset valid before", out_valid, 1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("midreset out_valid", out_valid, 0);
        checkOutput("midreset busy", busy, 0);
        checkOutput("midreset done", done, 0);
        checkOutput("midreset out_index", out_index, 0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        checkOutput("midreset no done", done, 0);
        applyStimulus(12'h200, 8, 2, "after reset");

`ifdef VBUFFER_FETCH_DEGEN_CULL_EN
        $display("[TB] degenerate cull pass");
        mem[12'h301][107:54] = mem[12'h301][53:0];
        applyStimulus(12'h300, 3, 0, "cull");
`endif

        $display("[TB] random passes");
        for (int r = 0; r < 8; r++) begin
            b = int'($urandom % DEPTH);
            c = (($urandom % 4) == 0) ? int'($urandom % 40) : int'(1 + $urandom % 12);
            applyStimulus(b, c, int'($urandom % 3), "random");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
